// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and default bundle widths for pipeline stage
//               registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int ID_EX_CTRL_W = 11;
    localparam int ID_EX_DATA_W = 160;
    localparam int DEF_CNT_W    = 16;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with enable and synchronous clear that sticks at
//               its maximum value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Back-pressurable pipeline stage register with 2-entry skid,
//               flush/bubble insertion and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = ID_EX_CTRL_W,
    parameter int DATA_W    = ID_EX_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter bit ZERO_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = CTRL_W + DATA_W;

    state_e        state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_ready_q;

    logic          w_accept;
    logic          w_drain;
    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_main_bubble;
    logic [PW-1:0] w_skid_bubble;

    assign w_in_payload = {in_ctrl, in_data};
    assign w_accept     = in_valid & in_ready_q;
    assign w_drain      = out_valid & out_ready;

    // A bubble always has zero control; data is optionally kept so that
    // downstream debug/forwarding sees the last value.
    assign w_main_bubble = ZERO_DATA ? '0 : {{CTRL_W{1'b0}}, main_q[DATA_W-1:0]};
    assign w_skid_bubble = ZERO_DATA ? '0 : {{CTRL_W{1'b0}}, skid_q[DATA_W-1:0]};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    state_d = ST_ONE;
                    main_d  = w_in_payload;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    main_d = w_in_payload;
                end else if (w_accept) begin
                    state_d = ST_TWO;
                    skid_d  = w_in_payload;
                end else if (w_drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (state_d == ST_EMPTY) begin
            main_d = w_main_bubble;
        end
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = w_main_bubble;
            skid_d  = w_skid_bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = out_valid ? main_q[PW-1 -: CTRL_W] : '0;
    assign out_data  = main_q[DATA_W-1:0];

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (out_valid & ~out_ready),
        .cnt_o (stall_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench; instance A uses default widths
//               with held data, instance B a 4-bit counter with zeroed data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int CW = 11;
    localparam int DW = 160;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_stall_cnt;

    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [3:0]    b_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16), .ZERO_DATA(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4), .ZERO_DATA(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .stall_cnt(b_stall_cnt)
    );

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int c, input int d);
        in_valid = v;
        in_ctrl  = CW'(c);
        in_data  = DW'(d);
    endtask

    // Both instances share stimulus; compare the common output view.
    task automatic check_both(input string tag, input logic v, input logic [CW-1:0] c,
                              input logic rdy);
        check({tag, " A valid"}, 192'(a_out_valid), 192'(v));
        check({tag, " A ctrl"},  192'(a_out_ctrl),  192'(c));
        check({tag, " A ready"}, 192'(a_in_ready),  192'(rdy));
        check({tag, " B valid"}, 192'(b_out_valid), 192'(v));
        check({tag, " B ctrl"},  192'(b_out_ctrl),  192'(c));
        check({tag, " B ready"}, 192'(b_in_ready),  192'(rdy));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 'h7FF, 'h1234);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 0, 0);
        check_both("reset", 1'b0, '0, 1'b1);
        check("reset A data",  192'(a_out_data),  192'(0));
        check("reset A stall", 192'(a_stall_cnt), 192'(0));
        check("reset B stall", 192'(b_stall_cnt), 192'(0));

        // Streaming: 1-cycle latency, full throughput
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, i, i);
            tick();
            check_both($sformatf("stream%0d", i), 1'b1, CW'(i), 1'b1);
            check($sformatf("stream%0d A data", i), 192'(a_out_data), 192'(i));
        end
        drive(1'b0, 0, 0);
        tick();
        check_both("stream end", 1'b0, '0, 1'b1);
        check("stream end A data", 192'(a_out_data), 192'(16));
        check("stream end B data", 192'(b_out_data), 192'(0));

        // Back-pressure: A in main, B in skid, C refused until space
        out_ready = 1'b0;
        drive(1'b1, 'h0A, 'hA0A);
        tick();
        check_both("bp A", 1'b1, 11'h0A, 1'b1);
        drive(1'b1, 'h0B, 'hB0B);
        tick();
        check_both("bp B skid", 1'b1, 11'h0A, 1'b0);
        drive(1'b1, 'h0C, 'hC0C);
        tick();
        check_both("bp C held1", 1'b1, 11'h0A, 1'b0);
        tick();
        check_both("bp C held2", 1'b1, 11'h0A, 1'b0);
        check("bp A stall", 192'(a_stall_cnt), 192'(3));
        out_ready = 1'b1;
        tick();
        check_both("bp out B", 1'b1, 11'h0B, 1'b1);
        check("bp out B data", 192'(a_out_data), 192'('hB0B));
        tick();
        check_both("bp out C", 1'b1, 11'h0C, 1'b1);
        check("bp out C data", 192'(a_out_data), 192'('hC0C));
        drive(1'b0, 0, 0);
        tick();
        check_both("bp empty", 1'b0, '0, 1'b1);
        check("bp A stall end", 192'(a_stall_cnt), 192'(3));
        check("bp B stall end", 192'(b_stall_cnt), 192'(3));

        // Flush while TWO with D presented
        out_ready = 1'b0;
        drive(1'b1, 'h0E, 'hE0E);
        tick();
        drive(1'b1, 'h0F, 'hF0F);
        tick();
        check_both("fl two", 1'b1, 11'h0E, 1'b0);
        flush = 1'b1;
        drive(1'b1, 'h0D, 'hD0D);
        tick();
        flush = 1'b0;
        drive(1'b0, 0, 0);
        check_both("fl bubble", 1'b0, '0, 1'b1);
        check("fl A data held", 192'(a_out_data), 192'('hE0E));
        check("fl B data zero", 192'(b_out_data), 192'(0));
        check("fl A stall", 192'(a_stall_cnt), 192'(5));
        out_ready = 1'b1;
        tick();
        check_both("fl no D", 1'b0, '0, 1'b1);

        // Flush coinciding with drain
        drive(1'b1, 'h011, 'h111);
        tick();
        flush = 1'b1;
        drive(1'b0, 0, 0);
        tick();
        flush = 1'b0;
        check_both("fl drain", 1'b0, '0, 1'b1);

        // Saturation: 20 stalled cycles plus a stalled flush cycle
        out_ready = 1'b0;
        drive(1'b1, 'h155, 'h5555);
        tick();
        drive(1'b0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        check("sat A stall", 192'(a_stall_cnt), 192'(25));
        check("sat B stall", 192'(b_stall_cnt), 192'(15));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat flush A stall", 192'(a_stall_cnt), 192'(26));
        check("sat flush B stall", 192'(b_stall_cnt), 192'(15));
        check_both("sat flushed", 1'b0, '0, 1'b1);

        // Data retention vs zeroing after last drain
        out_ready = 1'b1;
        drive(1'b1, 'h3FF, 'hABCD);
        tick();
        check_both("zd full", 1'b1, 11'h3FF, 1'b1);
        check("zd B data live", 192'(b_out_data), 192'('hABCD));
        drive(1'b0, 0, 0);
        tick();
        check_both("zd drained", 1'b0, '0, 1'b1);
        check("zd A data", 192'(a_out_data), 192'('hABCD));
        check("zd B data", 192'(b_out_data), 192'(0));
        check("zd B stall", 192'(b_stall_cnt), 192'(15));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, back-pressurable pipeline stage register that succeeds the fixed-width ID/EX latch. It carries a control bundle and a data bundle between two CPU pipeline stages with a valid/ready handshake, a 2-entry skid buffer for full throughput under stall, synchronous flush with guaranteed bubble (zero control) insertion, and a saturating stall-cycle counter. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- CTRL_W, 11, width of control bundle (WB/M/EX bits); zeroed on every bubble
- DATA_W, 160, width of data bundle (pc, operands, immediate, register ids, ...)
- CNT_W, 16, stall counter width
- ZERO_DATA, 0, 1 = data bundle also zeroed on bubble; 0 = data holds last value

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous flush; discards all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0
- out_data  out  DATA_W  data bundle
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main register (drives outputs) and skid register; state EMPTY, ONE (main valid), TWO (main+skid valid).
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY: accept -> ONE (main<=input).
- ONE: accept & drain -> ONE (main<=input); accept & !drain -> TWO (skid<=input); !accept & drain -> EMPTY; else hold.
- TWO: drain -> ONE (main<=skid); no accept possible (in_ready=0); else hold.
- in_ready = (state != TWO), registered; no combinational path out_ready -> in_ready.
- Flush (priority below rst, above all else): next state EMPTY, main/skid control zeroed, data zeroed iff ZERO_DATA; an entry presented with flush the same cycle is dropped, even if in_ready=1.
- out_ctrl forced zero when out_valid=0 (bubble semantics for downstream write enables), independent of stored contents.
- stall_cnt: +1 each cycle out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by rst (flush does not clear).
- Entries leave in arrival order; no entry duplicated or lost except by flush.

## Timing
- Reset values: out_valid=0, in_ready=1, out_ctrl=0, out_data=0, stall_cnt=0, state EMPTY.
- Latency: entry accepted in cycle N appears on outputs in cycle N+1 when stage was EMPTY or draining.
- Throughput: 1 entry/cycle with out_ready held high.
- in_ready drops in cycle after the skid fills; one in-flight entry absorbed by skid, none lost.
- Reset or flush mid-TWO: both entries discarded, in_ready=1 next cycle.
- Simultaneous flush & drain: drain counts as taken by downstream; stage still empties.
- Simultaneous accept and drain in TWO impossible by construction.

## Structure
- Shared package pipe_pkg: state enum (EMPTY/ONE/TWO), default widths per boundary (ID/EX CTRL_W=11, DATA_W=160).
- One natural sub-module: sat_counter (CNT_W, enable, synchronous clear, saturate); used for stall_cnt.
- Control and data concatenated internally into one payload; bubble masking applied at output.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_ctrl=0x7FF -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0 after release.
- Streaming: out_ready=1, push 0x001..0x010 ctrl/data on consecutive cycles -> same sequence out, 1-cycle latency, in_ready never 0.
- Back-pressure: out_ready=0 after entry A, push B, C -> B held in skid, in_ready=0, C not accepted; release -> A,B,C order, no loss; stall_cnt equals stalled cycles.
- Flush in TWO with new entry D presented: next cycle out_valid=0, out_ctrl=0, in_ready=1; D never emerges.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with valid entry -> stall_cnt stops at 15; flush leaves it at 15.
- ZERO_DATA=1 vs 0: after draining last entry 0xABCD -> out_data 0 vs 0xABCD, out_ctrl 0 in both.
